// File: rtl/fa_serial_add_ctrl.sv
// Bit-serial add/subtract sequencer driving one shared external full-adder cell.
// Operands are consumed LSB-first, one bit per clock, with the carry held between bits.
module fa_serial_add_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_ci,
  input  logic             fa_s,
  input  logic             fa_cout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             cout,
  output logic             ovf
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   sum_sh_q, sum_sh_d;
  logic [WIDTH-1:0]   s_q, s_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               run_s;

  assign run_s = (state_q == ST_RUN);

  // Subtraction is a + ~b + ~borrow_in, so b and the incoming carry are inverted at capture.
  always_comb begin
    state_d   = state_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    sum_sh_d  = sum_sh_q;
    s_d       = s_q;
    bit_cnt_d = bit_cnt_q;
    carry_d   = carry_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          a_sh_d    = a;
          b_sh_d    = sub ? ~b : b;
          carry_d   = ci ^ sub;
          bit_cnt_d = {CNT_W{1'b0}};
          sum_sh_d  = {WIDTH{1'b0}};
          state_d   = ST_RUN;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_RUN: begin
        carry_d   = fa_cout;
        sum_sh_d  = {fa_s, sum_sh_q[WIDTH-1:1]};
        a_sh_d    = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d    = {1'b0, b_sh_q[WIDTH-1:1]};
        bit_cnt_d = bit_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (bit_cnt_q == CNT_W'(WIDTH-1)) begin
          // carry_q is the carry into the MSB on this final bit
          s_d     = {fa_s, sum_sh_q[WIDTH-1:1]};
          cout_d  = fa_cout;
          ovf_d   = carry_q ^ fa_cout;
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      a_sh_q    <= {WIDTH{1'b0}};
      b_sh_q    <= {WIDTH{1'b0}};
      sum_sh_q  <= {WIDTH{1'b0}};
      s_q       <= {WIDTH{1'b0}};
      bit_cnt_q <= {CNT_W{1'b0}};
      carry_q   <= 1'b0;
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_sh_q    <= a_sh_d;
      b_sh_q    <= b_sh_d;
      sum_sh_q  <= sum_sh_d;
      s_q       <= s_d;
      bit_cnt_q <= bit_cnt_d;
      carry_q   <= carry_d;
      cout_q    <= cout_d;
      ovf_q     <= ovf_d;
    end
  end

  assign fa_a  = run_s & a_sh_q[0];
  assign fa_b  = run_s & b_sh_q[0];
  assign fa_ci = run_s & carry_q;
  assign busy  = run_s;
  assign done  = (state_q == ST_DONE);
  assign S     = s_q;
  assign cout  = cout_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_fa_serial_add_ctrl.sv
// Randomized bench for fa_serial_add_ctrl against an arithmetic reference model;
// the bench also provides the external full-adder cell.
module tb_fa_serial_add_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n, start, sub, ci;
  logic [W-1:0] a, b;
  logic         fa_a, fa_b, fa_ci, fa_s, fa_cout;
  logic         busy, done, cout, ovf;
  logic [W-1:0] S;

  int n_chk = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_done = 0;
  logic [W-1:0] prev_s = 8'h00;
  logic         prev_cout = 1'b0;
  logic         prev_ovf = 1'b0;

  fa_serial_add_ctrl #(.WIDTH(W), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b), .ci(ci),
    .fa_a(fa_a), .fa_b(fa_b), .fa_ci(fa_ci), .fa_s(fa_s), .fa_cout(fa_cout),
    .busy(busy), .done(done), .S(S), .cout(cout), .ovf(ovf)
  );

  assign fa_s    = fa_a ^ fa_b ^ fa_ci;
  assign fa_cout = (fa_a & fa_b) | (fa_a & fa_ci) | (fa_b & fa_ci);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: plain signed/unsigned arithmetic on the whole operands.
  function automatic void ref_model(input logic op_sub, input logic [W-1:0] ra, input logic [W-1:0] rb,
                                    input logic rci, output logic [W-1:0] rs, output logic rcout,
                                    output logic rovf);
    int ua, ub, sa, sb, c, t, ts;
    ua = int'(ra); ub = int'(rb); sa = $signed(ra); sb = $signed(rb); c = int'(rci);
    if (!op_sub) begin
      t = ua + ub + c;  rcout = (t >= 256); ts = sa + sb + c;
    end else begin
      t = ua - ub - c;  rcout = (t >= 0);   ts = sa - sb - c;
    end
    rs   = t[W-1:0];
    rovf = (ts > 127) || (ts < -128);
  endfunction

  task automatic chk_fa_zero(input string tag);
    chk({tag, "_fa_a"}, fa_a, 0);
    chk({tag, "_fa_b"}, fa_b, 0);
    chk({tag, "_fa_ci"}, fa_ci, 0);
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("idle_S", S, prev_s);
    chk_fa_zero("idle");
  endtask

  // Entered #1 after an edge with the DUT in IDLE or DONE; returns #1 after the DONE edge.
  task automatic do_op(input logic op_sub, input logic [W-1:0] oa, input logic [W-1:0] ob,
                       input logic oci, input bit glitch, input bit b2b);
    logic [W-1:0] bx, es;
    logic ec, eo;
    int m, cin;
    ref_model(op_sub, oa, ob, oci, es, ec, eo);
    bx = op_sub ? ~ob : ob;
    start = 1'b1; sub = op_sub; a = oa; b = ob; ci = oci;
    @(posedge clk); #1;
    start = 1'b0; sub = 1'($urandom); a = W'($urandom); b = W'($urandom); ci = 1'($urandom);
    for (int i = 0; i < W; i++) begin
      m   = (1 << i) - 1;
      cin = ((int'(oa) & m) + (int'(bx) & m) + int'(oci ^ op_sub)) >> i;
      chk("run_busy", busy, 1);
      chk("run_done", done, 0);
      chk("fa_a", fa_a, oa[i]);
      chk("fa_b", fa_b, bx[i]);
      chk("fa_ci", fa_ci, cin);
      chk("S_hold", S, prev_s);
      chk("cout_hold", cout, prev_cout);
      chk("ovf_hold", ovf, prev_ovf);
      if (glitch && i == 2) begin
        start = 1'b1; sub = 1'($urandom); a = W'($urandom); b = W'($urandom); ci = 1'($urandom);
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("done", done, 1);
    chk("done_busy", busy, 0);
    chk("S", S, es);
    chk("cout", cout, ec);
    chk("ovf", ovf, eo);
    chk_fa_zero("done");
    if (b2b) chk("b2b_gap", cyc - last_done, W + 1);
    last_done = cyc;
    prev_s = es; prev_cout = ec; prev_ovf = eo;
  endtask

  initial begin
    bit b2b_next;
    int gap;
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = 8'h00; b = 8'h00; ci = 1'b0;
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_S", S, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    chk_fa_zero("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle_cycle();

    do_op(1'b0, 8'h5A, 8'h3C, 1'b0, 1'b0, 1'b0);
    chk("dir_5a3c", {cout, ovf, S}, {2'b01, 8'h96});
    idle_cycle();
    do_op(1'b0, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
    chk("dir_ff01", {cout, ovf, S}, {2'b10, 8'h00});
    idle_cycle();
    do_op(1'b0, 8'hFF, 8'h01, 1'b1, 1'b0, 1'b0);
    chk("dir_ff01c", {cout, ovf, S}, {2'b10, 8'h01});
    idle_cycle();
    do_op(1'b1, 8'h10, 8'h20, 1'b0, 1'b0, 1'b0);
    chk("dir_sub1", {cout, ovf, S}, {2'b00, 8'hF0});
    idle_cycle();
    do_op(1'b1, 8'h80, 8'h01, 1'b0, 1'b1, 1'b0);
    chk("dir_sub2", {cout, ovf, S}, {2'b11, 8'h7F});
    do_op(1'b0, 8'h21, 8'h43, 1'b1, 1'b0, 1'b1);
    idle_cycle();

    // Reset in RUN cycle 4 abandons the operation.
    start = 1'b1; sub = 1'b0; a = 8'h77; b = 8'h19; ci = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_S", S, 0);
    chk("mrst_cout", cout, 0);
    chk("mrst_ovf", ovf, 0);
    chk_fa_zero("mrst");
    prev_s = 8'h00; prev_cout = 1'b0; prev_ovf = 1'b0;
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    repeat (W + 2) idle_cycle();
    do_op(1'b1, 8'h05, 8'h07, 1'b1, 1'b0, 1'b0);

    b2b_next = 1'b1;
    for (int k = 0; k < 40; k++) begin
      do_op(1'($urandom), W'($urandom), W'($urandom), 1'($urandom),
            ($urandom_range(0, 3) == 0), b2b_next);
      gap = $urandom_range(0, 2);
      repeat (gap) idle_cycle();
      b2b_next = (gap == 0);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
